mips_gpio_port: RTL and testbench
=================================

// Module: mips_gpio_port
// PURPOSE
// Memory-mapped GPIO peripheral on the data-memory bus of MIPS_Multi_Cycle.
// The core's load/store path addresses it. It drives GPIO_o from a register.
// It samples GPIO_i through a synchronizer and a per-bit debouncer, and records
// input changes in sticky flags. An optional level interrupt is raised toward the core.
// PARAMETERS
// WIDTH            8      number of GPIO pins per direction
// DEBOUNCE_CYCLES  16     consecutive stable cycles before an input change is accepted (>=1)
// OUT_RESET        8'h00  reset value of GPIO_o / DATA_OUT
// IN_RESET         8'hFF  reset value of synchronizer flops and DATA_IN (idle-high pins)
// PORTS
// clk      in   1      system clock, rising edge
// reset    in   1      asynchronous, active-low reset
// addr     in   4      byte address inside the block; bits[1:0] are ignored
// we       in   1      write strobe, one cycle per write
// re       in   1      read strobe, one cycle per read
// wdata    in   32     write data; only [WIDTH-1:0] is used
// rdata    out  32     read data, registered
// rvalid   out  1      high for exactly one cycle, the cycle after re
// GPIO_i   in   WIDTH  external input pins, asynchronous to clk
// GPIO_o   out  WIDTH  external output pins (DATA_OUT register)
// irq      out  1      |(EDGE_FLAGS & IRQ_EN)
// BEHAVIOUR
// Register map (word offsets):
// - 0x0 DATA_OUT, RW
// - 0x4 DATA_IN, RO (debounced value)
// - 0x8 EDGE_FLAGS, RW1C
// - 0xC IRQ_EN, RW
// - Upper data bits read as 0. Writes to DATA_IN are ignored.
// Reset values (reset=0, asynchronous): GPIO_o=OUT_RESET, sync stages=IN_RESET,
// DATA_IN=IN_RESET, debounce counters=0, EDGE_FLAGS=0, IRQ_EN=0, rdata=0, rvalid=0, irq=0.
// Write: on the clk edge with we=1, the register updates. GPIO_o changes at that same edge.
// Read: re=1 at edge k gives rdata/rvalid at edge k+1.
// - The value returned is the register contents before any write at edge k (old value).
// - rdata holds its value until the next read; rvalid drops after one cycle.
// - re and we are allowed in the same cycle, to the same or different addresses.
// Input path:
// - 2-flop synchronizer on each bit gives sync[i].
// - Per-bit counter cnt[i]. When sync[i]==DATA_IN[i], cnt[i] clears to 0.
// - Otherwise cnt[i] increments. On the edge where the count of consecutive mismatches
//   reaches DEBOUNCE_CYCLES, DATA_IN[i]<=sync[i], EDGE_FLAGS[i]<=1 and cnt[i]<=0.
// - A pin change sampled at edge t is visible in DATA_IN at edge t+1+DEBOUNCE_CYCLES.
// - A glitch shorter than DEBOUNCE_CYCLES synced cycles causes no change and no flag.
// - The counter saturates; it cannot wrap.
// EDGE_FLAGS:
// - Each bit is set on any accepted change, rising or falling.
// - A write of 1 clears the bit; a write of 0 has no effect.
// - If a set and a W1C clear hit the same bit on the same edge, the set wins.
// irq is combinational from the registers. It deasserts the cycle after the last enabled flag clears.
// Reset asserted mid-operation aborts any debounce count. No flag is produced for pins
// that differ from IN_RESET at reset release until they complete a full debounce.
// TESTING (DEBOUNCE_CYCLES=4 unless stated)
// 1. Reset with GPIO_i=8'hFF, then release -> GPIO_o=8'h00, DATA_IN reads 8'hFF,
//    EDGE_FLAGS reads 0, irq=0.
// 2. Write 0x0<=32'h0000_00A5, then read 0x0 -> GPIO_o=8'hA5 at the write edge;
//    rdata=32'h0000_00A5 with rvalid one cycle after re.
// 3. GPIO_i 8'hFF->8'h00 held -> DATA_IN=8'h00 exactly 5 edges after the sampling edge;
//    EDGE_FLAGS=8'hFF. With IRQ_EN=8'h01, irq=1.
// 4. GPIO_i[3] pulsed low for 3 cycles -> DATA_IN unchanged, EDGE_FLAGS[3]=0.
// 5. Write 0x8<=8'h01 on the same edge bit0 changes again -> flag stays 1 (set wins).
//    A later write 0x8<=8'hFF clears it; irq drops.
// 6. Assert reset mid-debounce (count=2), then release -> no DATA_IN change, no flag,
//    counter restarts from 0.

Source files
------------

// File: rtl/mips_gpio_port_if.sv
// Data-memory bus between the MIPS multi-cycle core (master) and the GPIO port (slave).
// Read data is registered in the slave and qualified by a one-cycle rvalid.
interface mips_gpio_port_if;
  logic [3:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output addr, we, re, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  addr, we, re, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO port: output register, synchronized and debounced inputs,
// sticky change flags with write-one-to-clear, and a level interrupt.
module mips_gpio_port #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] OUT_RESET       = '0,
  parameter logic [WIDTH-1:0] IN_RESET        = '1
) (
  input  logic             clk,
  input  logic             reset,
  mips_gpio_port_if.slave  bus,
  input  logic [WIDTH-1:0] GPIO_i,
  output logic [WIDTH-1:0] GPIO_o,
  output logic             irq
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RegDataOut   = 2'd0,
    RegDataIn    = 2'd1,
    RegEdgeFlags = 2'd2,
    RegIrqEn     = 2'd3
  } reg_sel_e;

  reg_sel_e sel;
  assign sel = reg_sel_e'(bus.addr[3:2]);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  // Address bits [1:0] and wdata bits above WIDTH are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  // Counter only advances while mismatched and clears on acceptance, so it never
  // exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
  always_comb begin
    accept = '0;
    cnt_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] != data_in_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    data_in_d = data_in_q ^ accept;
  end

  always_comb begin
    out_d    = out_q;
    irq_en_d = irq_en_q;
    w1c      = '0;
    if (bus.we) begin
      unique case (sel)
        RegDataOut:   out_d    = bus.wdata[WIDTH-1:0];
        RegIrqEn:     irq_en_d = bus.wdata[WIDTH-1:0];
        RegEdgeFlags: w1c      = bus.wdata[WIDTH-1:0];
        default:      ;
      endcase
    end
    // A new change flag beats a simultaneous clear.
    edge_d = (edge_q & ~w1c) | accept;
  end

  always_comb begin
    unique case (sel)
      RegDataOut:   rd_word = out_q;
      RegDataIn:    rd_word = data_in_q;
      RegEdgeFlags: rd_word = edge_q;
      default:      rd_word = irq_en_q;
    endcase
    rdata_d  = rdata_q;
    rvalid_d = bus.re;
    if (bus.re) begin
      rdata_d              = '0;
      rdata_d[WIDTH-1:0]   = rd_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= IN_RESET;
      sync2_q   <= IN_RESET;
      data_in_q <= IN_RESET;
      cnt_q     <= '0;
      edge_q    <= '0;
      irq_en_q  <= '0;
      out_q     <= OUT_RESET;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      sync1_q   <= GPIO_i;
      sync2_q   <= sync1_q;
      data_in_q <= data_in_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      irq_en_q  <= irq_en_d;
      out_q     <= out_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign GPIO_o     = out_q;
  assign irq        = |(edge_q & irq_en_q);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_mips_gpio_port.sv
// Self-checking bench for mips_gpio_port: directed vector table, hand-written debounce,
// W1C and reset sequences, then random traffic against a behavioural model.
module tb_mips_gpio_port;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] gpio_i;
  logic [W-1:0] gpio_o;
  logic         irq;

  mips_gpio_port_if bus ();

  mips_gpio_port #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .OUT_RESET      (8'h00),
    .IN_RESET       (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .GPIO_i(gpio_i),
    .GPIO_o(gpio_o),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [W-1:0] m_out, m_din, m_flags, m_irqen;
  logic [31:0]  m_rdata;
  logic         m_rvalid;
  logic [W-1:0] pin_q[$];   // pin samples still travelling through the synchronizer
  logic [W-1:0] seen_q[$];  // most recent synchronized samples, newest last

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  exp_o;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out    = 8'h00;
    m_din    = 8'hFF;
    m_flags  = '0;
    m_irqen  = '0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    pin_q    = '{8'hFF, 8'hFF};
    seen_q.delete();
  endtask

  // A bit is accepted once the last D synchronized samples all disagree with DATA_IN.
  task automatic model_step();
    logic [W-1:0] s, acc, clr;
    int run;
    s = pin_q[0];
    seen_q.push_back(s);
    if (seen_q.size() > D) void'(seen_q.pop_front());
    acc = '0;
    for (int b = 0; b < W; b++) begin
      run = 0;
      for (int k = seen_q.size() - 1; k >= 0; k--) begin
        if (seen_q[k][b] != m_din[b]) run++;
        else break;
      end
      acc[b] = (run >= D);
    end
    if (bus.re) begin
      m_rdata = '0;
      case (bus.addr[3:2])
        2'd0:    m_rdata[W-1:0] = m_out;
        2'd1:    m_rdata[W-1:0] = m_din;
        2'd2:    m_rdata[W-1:0] = m_flags;
        default: m_rdata[W-1:0] = m_irqen;
      endcase
    end
    m_rvalid = bus.re;
    clr = (bus.we && bus.addr[3:2] == 2'd2) ? bus.wdata[W-1:0] : '0;
    m_flags = (m_flags & ~clr) | acc;
    m_din   = m_din ^ acc;
    if (bus.we && bus.addr[3:2] == 2'd0) m_out   = bus.wdata[W-1:0];
    if (bus.we && bus.addr[3:2] == 2'd3) m_irqen = bus.wdata[W-1:0];
    void'(pin_q.pop_front());
    pin_q.push_back(gpio_i);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic we, input logic re, input logic [3:0] addr,
                        input logic [31:0] wdata);
    bus.we    = we;
    bus.re    = re;
    bus.addr  = addr;
    bus.wdata = wdata;
    tick();
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic read_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    bus_op(1'b0, 1'b1, addr, 32'h0);
    check({name, "_rvalid"}, {31'b0, bus.rvalid}, 32'h1);
    check(name, bus.rdata, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_gpio_o"}, {24'b0, gpio_o}, {24'b0, m_out});
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, |(m_flags & m_irqen)});
    check({tag, "_rvalid"}, {31'b0, bus.rvalid}, {31'b0, m_rvalid});
    check({tag, "_rdata"}, bus.rdata, m_rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0000_00A5, 8'hA5, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'h0, 32'h0000_0000, 8'hA5, 1'b1, 32'h0000_00A5, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 8'hA5, 1'b0, 32'h0000_00A5, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'h0, 32'h0000_003C, 8'h3C, 1'b1, 32'h0000_00A5, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 4'hC, 32'h0000_0101, 8'h3C, 1'b0, 32'h0000_00A5, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 4'hC, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0001, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 4'h4, 32'h0000_0000, 8'h3C, 1'b0, 32'h0000_0001, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 4'h4, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_00FF, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 4'h2, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_003C, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 4'hD, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0001, 1'b0};

    // Reset with idle-high pins
    reset     = 1'b0;
    gpio_i    = 8'hFF;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.addr  = 4'h0;
    bus.wdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    check("rst_gpio_o", {24'b0, gpio_o}, 32'h00);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    read_reg("rst_data_in", 4'h4, 32'hFF);
    read_reg("rst_flags", 4'h8, 32'h00);

    // Register access table
    for (int i = 0; i < 10; i++) begin
      bus.we    = vecs[i].we;
      bus.re    = vecs[i].re;
      bus.addr  = vecs[i].addr;
      bus.wdata = vecs[i].wdata;
      tick();
      check($sformatf("vec%0d_gpio_o", i), {24'b0, gpio_o}, {24'b0, vecs[i].exp_o});
      check($sformatf("vec%0d_rvalid", i), {31'b0, bus.rvalid}, {31'b0, vecs[i].exp_rv});
      check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end
    bus.we = 1'b0;
    bus.re = 1'b0;

    // All pins fall; acceptance lands exactly D+1 edges after the sampling edge
    gpio_i = 8'h00;
    for (int k = 0; k <= D; k++) begin
      tick();
      check($sformatf("fall_irq_pre%0d", k), {31'b0, irq}, 32'h0);
    end
    tick();
    check("fall_irq_set", {31'b0, irq}, 32'h1);
    read_reg("fall_data_in", 4'h4, 32'h00);
    read_reg("fall_flags", 4'h8, 32'hFF);

    // Restore pins, clear flags, then a 3-cycle glitch on bit 3
    gpio_i = 8'hFF;
    repeat (8) tick();
    bus_op(1'b1, 1'b0, 4'h8, 32'hFF);
    check("clr_irq", {31'b0, irq}, 32'h0);
    gpio_i = 8'hF7;
    repeat (3) tick();
    gpio_i = 8'hFF;
    repeat (10) tick();
    read_reg("glitch_data_in", 4'h4, 32'hFF);
    read_reg("glitch_flags", 4'h8, 32'h00);

    // Set on bit 0 coincides with a W1C of bit 0: set wins
    gpio_i = 8'hFE;
    repeat (D + 1) tick();
    check("setwin_irq_pre", {31'b0, irq}, 32'h0);
    bus_op(1'b1, 1'b0, 4'h8, 32'h01);
    check("setwin_irq", {31'b0, irq}, 32'h1);
    read_reg("setwin_flags", 4'h8, 32'h01);
    bus_op(1'b1, 1'b0, 4'h8, 32'hFF);
    check("setwin_clr_irq", {31'b0, irq}, 32'h0);
    read_reg("setwin_clr_flags", 4'h8, 32'h00);

    // Reset in the middle of a debounce on bit 7 (count = 2)
    gpio_i = 8'h7E;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    check("mrst_gpio_o", {24'b0, gpio_o}, 32'h00);
    check("mrst_irq", {31'b0, irq}, 32'h0);
    check("mrst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    bus_op(1'b1, 1'b0, 4'hC, 32'h80);
    for (int k = 0; k < D; k++) begin
      tick();
      check($sformatf("mrst_irq_pre%0d", k), {31'b0, irq}, 32'h0);
    end
    tick();
    check("mrst_irq_set", {31'b0, irq}, 32'h1);
    read_reg("mrst_data_in", 4'h4, 32'h7E);
    read_reg("mrst_flags", 4'h8, 32'h81);

    // Random traffic against the model
    check_model("sync");
    for (int n = 0; n < 600; n++) begin
      bus.we    = ($urandom_range(0, 3) == 0);
      bus.re    = ($urandom_range(0, 2) == 0);
      bus.addr  = 4'($urandom_range(0, 15));
      bus.wdata = $urandom;
      if ($urandom_range(0, 5) == 0) gpio_i = gpio_i ^ (8'h01 << $urandom_range(0, 7));
      tick();
      check_model($sformatf("rnd%0d", n));
    end
    bus.we = 1'b0;
    bus.re = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
